// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that time-shares one psdsqrt unit among N requesters and
// sequences each conversion (latch, start pulse, fixed run window, stop pulse, capture).
module sqrt_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned SQRT_CYCLES = 18,
  localparam int unsigned GrantW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      req_i,
  input  logic [32*N-1:0]   xin_i,
  output logic [N-1:0]      done_o,
  output logic [15:0]       result_o,
  output logic              busy_o,
  output logic [GrantW-1:0] grant_o,
  output logic              sq_start_o,
  output logic              sq_stop_o,
  output logic [31:0]       sq_xin_o,
  input  logic [15:0]       sq_sqrt_i
);

  localparam int unsigned CntW = $clog2(SQRT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StStart, StRun, StStop, StDone} state_e;

  state_e            state_q;
  logic [GrantW-1:0] rr_q;
  logic [GrantW-1:0] grant_q;
  logic [CntW-1:0]   cnt_q;
  logic [N-1:0]      done_q;
  logic [15:0]       result_q;
  logic              busy_q;
  logic              sq_start_q;
  logic              sq_stop_q;
  logic [31:0]       sq_xin_q;

  logic              pick_valid;
  logic [GrantW-1:0] pick_idx;
  logic [GrantW-1:0] cand;
  logic [GrantW-1:0] rr_next;

  // First requester at or after the rr pointer, scanning upward with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = GrantW'((32'(rr_q) + k) % N);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign rr_next = (grant_q == GrantW'(N - 1)) ? '0 : grant_q + GrantW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      sq_start_q <= 1'b0;
      sq_stop_q  <= 1'b0;
      sq_xin_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q    <= pick_idx;
            sq_xin_q   <= xin_i[{pick_idx, 5'd0} +: 32];
            sq_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          sq_start_q <= 1'b0;
          cnt_q      <= CntW'(SQRT_CYCLES - 1);
          state_q    <= StRun;
        end
        StRun: begin
          if (cnt_q == '0) begin
            sq_stop_q <= 1'b1;
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStop: begin
          sq_stop_q <= 1'b0;
          result_q  <= sq_sqrt_i;
          // A requester that withdrew mid-conversion gets no strobe.
          done_q    <= {{(N-1){1'b0}}, req_i[grant_q]} << grant_q;
          state_q   <= StDone;
        end
        StDone: begin
          done_q  <= '0;
          rr_q    <= rr_next;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o     = done_q;
  assign result_o   = result_q;
  assign busy_o     = busy_q;
  assign grant_o    = grant_q;
  assign sq_start_o = sq_start_q;
  assign sq_stop_o  = sq_stop_q;
  assign sq_xin_o   = sq_xin_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: psdsqrt stub, scoreboard of expected done strobes and
// table-driven single requests plus hand-written multi-cycle sequences.
module tb_sqrt_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned SC = 18;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req   = '0;
  logic [127:0] xin   = '0;
  logic [3:0]   done;
  logic [15:0]  result;
  logic         busy;
  logic [1:0]   grant;
  logic         sq_start;
  logic         sq_stop;
  logic [31:0]  sq_xin;
  logic [15:0]  sq_sqrt;

  sqrt_arbiter #(.N(N), .SQRT_CYCLES(SC)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req),
    .xin_i      (xin),
    .done_o     (done),
    .result_o   (result),
    .busy_o     (busy),
    .grant_o    (grant),
    .sq_start_o (sq_start),
    .sq_stop_o  (sq_stop),
    .sq_xin_o   (sq_xin),
    .sq_sqrt_i  (sq_sqrt)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint unsigned r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= 64'(x)) r = t;
    end
    return r[15:0];
  endfunction

  // psdsqrt stub: result only valid if stop arrives SC or more cycles after start.
  logic [31:0] stub_x   = '0;
  int          stub_cnt = 0;
  always @(posedge clock) begin
    if (sq_start) begin
      stub_x   <= sq_xin;
      stub_cnt <= 0;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign sq_sqrt = (sq_stop && stub_cnt >= SC) ? isqrt(stub_x) : 16'hdead;

  typedef struct {
    logic [3:0]  onehot;
    logic [15:0] res;
  } exp_t;

  typedef struct {
    int          idx;
    logic [31:0] x;
    logic [15:0] res;
  } vec_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, start_cyc = 0, stop_cyc = 0, done_cyc = 0, done_idx = 0;
  int   overlap = 0;
  bit   done_seen, stop_seen;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (sq_start && sq_stop) overlap++;
    if (sq_start) start_cyc = cyc;
    if (sq_stop) begin
      stop_cyc  = cyc;
      stop_seen = 1'b1;
    end
    if (done != 0) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      for (int k = 0; k < 4; k++) if (done[k]) done_idx = k;
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = q.pop_front();
        chk("done_onehot", 64'(done), 64'(e.onehot));
        chk("done_result", 64'(result), 64'(e.res));
      end
    end
  endtask

  task automatic wait_done(input string name);
    done_seen = 1'b0;
    for (int i = 0; i < 60 && !done_seen; i++) tick();
    if (!done_seen) chk(name, 64'(done_seen), 64'd1);
  endtask

  task automatic wait_stop(input string name);
    stop_seen = 1'b0;
    for (int i = 0; i < 60 && !stop_seen; i++) tick();
    if (!stop_seen) chk(name, 64'(stop_seen), 64'd1);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_result"}, 64'(result), 64'd0);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_grant"}, 64'(grant), 64'd0);
    chk({p, "_sq_start"}, 64'(sq_start), 64'd0);
    chk({p, "_sq_stop"}, 64'(sq_stop), 64'd0);
    chk({p, "_sq_xin"}, 64'(sq_xin), 64'd0);
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[6];
    int   t0, prev, idle_bad;

    vt[0] = '{0, 32'd456, 16'd21};
    vt[1] = '{1, 32'd0, 16'd0};
    vt[2] = '{2, 32'd1, 16'd1};
    vt[3] = '{3, 32'd99, 16'd9};
    vt[4] = '{0, 32'hffff_ffff, 16'd65535};
    vt[5] = '{2, 32'd1000000, 16'd1000};

    tick();
    check_zero("reset");
    reset = 1'b1;
    tick();

    // Single requests: latency start=1, stop=20, done=21, idle at 22.
    for (int i = 0; i < 6; i++) begin
      t0 = cyc;
      xin[32*vt[i].idx +: 32] = vt[i].x;
      req[vt[i].idx] = 1'b1;
      q.push_back('{4'b0001 << vt[i].idx, vt[i].res});
      wait_done("single_wait");
      chk("single_start_cyc", 64'(start_cyc - t0), 64'd1);
      chk("single_stop_cyc", 64'(stop_cyc - t0), 64'd20);
      chk("single_done_cyc", 64'(done_cyc - t0), 64'd21);
      req = '0;
      tick();
      chk("single_busy_after", 64'(busy), 64'd0);
    end

    // Round-robin over all four requesters.
    do_reset();
    xin = {32'hffff_ffff, 32'd65536, 32'd100, 32'd16};
    req = 4'b1111;
    q.push_back('{4'b0001, 16'd4});
    q.push_back('{4'b0010, 16'd10});
    q.push_back('{4'b0100, 16'd256});
    q.push_back('{4'b1000, 16'd65535});
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done("rr_wait");
      chk("rr_order", 64'(done_idx), 64'(i));
      if (i > 0) chk("rr_spacing", 64'(done_cyc - prev), 64'd22);
      prev = done_cyc;
      req[done_idx] = 1'b0;
    end
    tick();

    // Fairness: req[2] held, req[0] re-raised after each of its dones.
    do_reset();
    xin = '0;
    xin[31:0]  = 32'd25;
    xin[95:64] = 32'd81;
    req = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      q.push_back('{4'b0001, 16'd5});
      q.push_back('{4'b0100, 16'd9});
    end
    for (int i = 0; i < 4; i++) begin
      wait_done("fair_wait");
      chk("fair_order", 64'(done_idx), 64'((i % 2) * 2));
      if (i == 3) begin
        req = '0;
      end else if (done_idx == 0) begin
        req[0] = 1'b0;
        tick();
        req[0] = 1'b1;
      end
    end
    tick();

    // Operand changed after grant is ignored.
    do_reset();
    xin[31:0] = 32'd456;
    req = 4'b0001;
    q.push_back('{4'b0001, 16'd21});
    tick();
    tick();
    xin[31:0] = 32'd9;
    wait_done("operand_wait");
    req = '0;
    tick();

    // Withdrawn request: conversion completes silently, next requester follows.
    xin[63:32]   = 32'd400;
    xin[127:96]  = 32'd49;
    req = 4'b1010;
    q.push_back('{4'b1000, 16'd7});
    repeat (5) tick();
    chk("withdrawn_grant", 64'(grant), 64'd1);
    req[1] = 1'b0;
    wait_stop("withdrawn_stop_wait");
    tick();
    chk("withdrawn_no_done", 64'(done), 64'd0);
    chk("withdrawn_result", 64'(result), 64'd20);
    wait_done("withdrawn_next_wait");
    chk("withdrawn_next_idx", 64'(done_idx), 64'd3);
    req = '0;
    tick();

    // Async reset in RUN: outputs clear before the next clock edge.
    xin[95:64] = 32'd1000000;
    req = 4'b0100;
    repeat (10) tick();
    chk("async_busy_before", 64'(busy), 64'd1);
    #1 reset = 1'b0;
    #1 check_zero("async");
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    xin[127:96] = 32'd144;
    req = 4'b1000;
    q.push_back('{4'b1000, 16'd12});
    wait_done("after_reset_wait");
    chk("after_reset_grant", 64'(grant), 64'd3);
    req = '0;
    tick();

    // Idle: nothing moves without requests.
    idle_bad = 0;
    repeat (50) begin
      tick();
      if (sq_start || sq_stop || busy || done != 0) idle_bad++;
    end
    chk("idle_quiet", 64'(idle_bad), 64'd0);

    chk("start_stop_overlap", 64'(overlap), 64'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one psdsqrt square-root unit among N requesters.
- Round-robin arbitration between requesters.
- Sequences each conversion: latch operand, start pulse, fixed run window, stop pulse, result capture.
- Returns the 16-bit result to the granted requester with a one-cycle done strobe.
- Sits between the lab datapath clients and the single psdsqrt instance.

Parameters:
- N, 4, number of requesters (2..8).
- SQRT_CYCLES, 18, clock cycles psdsqrt needs between start and stop for a valid result.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req  in  N  per-requester level request; hold high until own done bit.
- xin  in  N*32  operands, requester i in bits [32*i+31:32*i].
- done  out  N  one-hot, one-cycle strobe; result valid in the same cycle.
- result  out  16  sqrt of the granted operand; holds until the next capture.
- busy  out  1  high whenever FSM is not IDLE.
- grant  out  log2(N) (min 1)  index of the current/last granted requester.
- sq_start  out  1  to psdsqrt start.
- sq_stop  out  1  to psdsqrt stop.
- sq_xin  out  32  to psdsqrt xin.
- sq_sqrt  in  16  from psdsqrt sqrt.

Behaviour:
- Reset (reset low, async): state=IDLE; done=0; result=0; busy=0; grant=0; sq_start=0; sq_stop=0; sq_xin=0; rr pointer=0; run counter=0. All outputs registered.
- States: IDLE -> START -> RUN -> STOP -> DONE -> IDLE.
- IDLE:
  - If any req bit is high at a clock edge, choose the first requester at or after the rr pointer, scanning upward with wrap (N-1 -> 0).
  - On that edge: grant <= idx; sq_xin <= xin[idx]; state <= START.
  - No request: remain in IDLE, outputs unchanged.
- START: sq_start=1 for exactly this one cycle; counter loaded with SQRT_CYCLES-1.
- RUN:
  - Lasts exactly SQRT_CYCLES cycles; counter decrements each cycle.
  - Leave RUN when counter==0.
  - sq_start=0 and sq_stop=0 throughout.
- STOP:
  - sq_stop=1 for exactly this one cycle.
  - At the edge ending STOP: result <= sq_sqrt.
- DONE:
  - done[grant]=1 for one cycle if req[grant] is still high; otherwise done stays 0 and result is still updated.
  - rr pointer <= grant+1 mod N.
  - Next state IDLE.
- Timing (cycle 0 = the IDLE cycle whose ending edge grants):
  - start in cycle 1; RUN in cycles 2..SQRT_CYCLES+1; stop in cycle SQRT_CYCLES+2; done in cycle SQRT_CYCLES+3.
  - Default SQRT_CYCLES=18: start in cycle 1, stop in cycle 20, done in cycle 21.
  - Back-to-back throughput: one conversion per SQRT_CYCLES+4 cycles (IDLE occupies at least one cycle).
- Operand stability: sq_xin changes only on a grant edge and is stable from START through STOP. xin changes after the grant are ignored.
- Requests arriving while busy are queued implicitly, because req is level-held; no request is lost.
- req dropped mid-operation: the conversion still runs to completion and no done is issued. The pointer still advances.
- Simultaneous requests: round-robin fairness; a continuously requesting client waits at most N-1 conversions.
- Requester i must deassert req in the cycle after done[i]. If req remains high it is re-arbitrated as a new request, and the pointer has moved past it.
- Reset asserted mid-operation: immediate return to the reset values. sq_start and sq_stop drop asynchronously; no done is issued.
- Exactly one of sq_start/sq_stop may be high in any cycle; never both.

Test Plan:
- Bench model: behavioural psdsqrt stub with result=floor(sqrt(xin)), valid once sq_stop is seen after SQRT_CYCLES.
- Single request: req[0]=1, xin0=456 -> sq_start in cycle 1; sq_stop in cycle 20; done=0001 and result=21 in cycle 21; busy low in cycle 22.
- Round-robin: req=1111, xin0..3 = 16, 100, 65536, 4294967295.
  - Required order of done: 0,1,2,3.
  - Required results: 4, 10, 256, 65535.
  - Done strobes 22 cycles apart.
- Fairness: req[2] held continuously while req[0] is re-raised after each done -> alternating grants 0,2,0,2.
- Operand change and withdrawn request:
  - Change xin0 from 456 to 9 two cycles after grant -> result=21.
  - Separately, drop req[1] in RUN -> no done, result still updated, next grant proceeds.
- Async reset: pull reset low during RUN (cycle 10) -> all outputs 0 immediately, before the next clock edge. After release with req[3]=1, xin3=144 -> done=1000, result=12.
- Idle check: no req for 50 cycles -> sq_start, sq_stop, done and busy all remain 0.
